nios2_led_pwm: RTL and testbench
================================

# nios2_led_pwm

Avalon-MM memory-mapped LED output controller for the Nios II system; the successor to the plain 18-bit LED output port. Provides a parametrised channel count, atomic set/clear access, per-channel PWM brightness with glitch-free duty updates, and an optional hardware blink function. Sits on the Nios II data master as a zero-wait-state slave and drives the board LEDs or ambilight strip enables directly.

## Interface
- NUM_CH, 18, number of output channels (1..24)
- PWM_BITS, 8, duty/PWM counter resolution in bits (1..16)
- ADDR_W, 5, word address width (fixed map needs 5)
- clk  in  1  system clock
- reset_n  in  1  reset: asynchronous, active-low
- address  in  ADDR_W  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; write occurs when chipselect && !write_n
- writedata  in  32  write data
- readdata  out  32  combinational read data, zero wait states, unused bits 0
- out_port  out  NUM_CH  registered LED drive
- pwm_sync  out  1  one-cycle pulse on the first clock of each PWM period

## Operation
- Register map (word offsets):
  - 0 DATA: R/W channel on/off mask [NUM_CH-1:0]
  - 1 SET: write-1 sets DATA bits, reads 0
  - 2 CLEAR: write-1 clears DATA bits, reads 0
  - 3 PRESCALE: R/W [15:0]; PWM tick every PRESCALE+1 clocks
  - 4 BLINK_MASK, 5 BLINK_PERIOD: see Configuration
  - 8+i DUTY[i], i<NUM_CH: R/W [PWM_BITS-1:0]
  - Other addresses: read 0, writes ignored
- Reset values: DATA 0, PRESCALE 0, every DUTY all-ones, counters 0, out_port 0, pwm_sync 0. With these values the block behaves as a plain on/off port.
- Timebase:
  - presc_cnt counts 0..PRESCALE; tick when presc_cnt==PRESCALE, then presc_cnt returns to 0.
  - pwm_cnt (PWM_BITS wide) increments on tick and wraps from all-ones to 0.
  - A write to PRESCALE clears presc_cnt in the same cycle; pwm_cnt is unaffected.
- Duty double buffering:
  - A write to DUTY[i] updates shadow[i]. Readback returns shadow[i].
  - active[i] loads from shadow[i] only on the tick where pwm_cnt wraps to 0, so duty changes never truncate a period.
- Channel output: on[i] = DATA[i] && (active[i]==all-ones || pwm_cnt < active[i]). A duty of 0 means always off; all-ones means always on.
- DATA, SET and CLEAR act immediately, mid-period, with no buffering.
- Writes ignore writedata bits above the field width.

## Timing
- out_port is registered on[i]: 1 clock latency from the pwm_cnt/DATA change.
- DATA write at edge N: out_port reflects it after edge N+1.
- pwm_sync is asserted for the single clock in which pwm_cnt==0 and presc_cnt==0.
- PWM period = (PRESCALE+1)·2^PWM_BITS clocks. High time = active·(PRESCALE+1) clocks.
- Reset asserted mid-period: all registers and outputs clear asynchronously, and DUTY returns to all-ones. The first period after release starts at pwm_cnt 0.

## Configuration
- LED_PWM_BLINK_EN defined:
  - BLINK_MASK [NUM_CH-1:0] and BLINK_PERIOD [15:0] are R/W, both reset to 0.
  - blink_cnt counts PWM periods (on wrap ticks) 0..BLINK_PERIOD. At terminal count it resets and toggles blink_phase (reset 0).
  - While blink_phase==1, channels with a BLINK_MASK bit set are forced off.
  - A write to BLINK_PERIOD clears blink_cnt and blink_phase.
- LED_PWM_BLINK_EN undefined: offsets 4 and 5 read 0, writes are ignored, and no blink logic is synthesised.

## Structure
- Package nios2_led_pwm_pkg:
  - Register offset constants: REG_DATA, REG_SET, REG_CLEAR, REG_PRESCALE, REG_BLINK_MASK, REG_BLINK_PERIOD, REG_DUTY_BASE.
  - PRESCALE_W=16, BLINK_W=16.
- Sub-module nios2_led_pwm_timebase: prescaler, pwm_cnt, wrap strobe, pwm_sync and, when enabled, blink counter/phase. Outputs pwm_cnt, period_wrap and blink_phase.
- The top level holds the register file, duty shadow/active arrays, output compare and read mux.

## Test plan
- Reset, then write DATA=0x3FFFF at defaults → out_port=0x3FFFF one clock later. Read DATA returns 0x3FFFF.
- DATA=0x00F0, SET 0x0003, CLEAR 0x0010 → DATA reads 0x00E3. SET and CLEAR read 0.
- PRESCALE=0, DATA[0]=1, DUTY[0]=64 → out_port[0] high for 64 of every 256 clocks, aligned one clock after pwm_sync. DUTY=0 → constantly low. DUTY=255 → constantly high.
- Write DUTY[0]=32 at pwm_cnt=100 with active=64 → the current period keeps a 64-clock high time; 32 takes effect from the next pwm_sync.
- PRESCALE=3 → pwm_sync spacing 1024 clocks. Rewrite PRESCALE mid-count → presc_cnt restarts at 0.
- With LED_PWM_BLINK_EN: BLINK_MASK=1, BLINK_PERIOD=1, DUTY all-ones → out_port[0] toggles every 2 PWM periods (512 clocks). Without the macro, offset 5 reads 0 after a write.

Source files
------------

// File: rtl/nios2_led_pwm_pkg.sv
// Shared constants for the nios2_led_pwm LED controller: register map and field widths.
// Blink registers only take effect in builds with LED_PWM_BLINK_EN defined.
package nios2_led_pwm_pkg;

    localparam int unsigned PRESCALE_W = 16;
    localparam int unsigned BLINK_W    = 16;

    localparam int unsigned REG_DATA         = 0;
    localparam int unsigned REG_SET          = 1;
    localparam int unsigned REG_CLEAR        = 2;
    localparam int unsigned REG_PRESCALE     = 3;
    localparam int unsigned REG_BLINK_MASK   = 4;
    localparam int unsigned REG_BLINK_PERIOD = 5;
    localparam int unsigned REG_DUTY_BASE    = 8;

endpackage

// File: rtl/nios2_led_pwm_timebase.sv
// PWM timebase: prescaler, PWM counter, period-wrap strobe, registered pwm_sync pulse.
// With LED_PWM_BLINK_EN defined it also counts PWM periods and drives the blink phase.
module nios2_led_pwm_timebase
    import nios2_led_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  prescale_wr_i,
`ifdef LED_PWM_BLINK_EN
    input  logic [BLINK_W-1:0]    blink_period_i,
    input  logic                  blink_period_wr_i,
    output logic                  blink_phase_o,
`endif
    output logic [PWM_BITS-1:0]   pwm_cnt_o,
    output logic                  period_wrap_o,
    output logic                  pwm_sync_o
);

    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic                  sync_q, sync_d;
    logic                  tick;

    assign tick          = (presc_cnt_q == prescale_i);
    assign period_wrap_o = tick && (pwm_cnt_q == '1);

    always_comb begin
        presc_cnt_d = tick ? '0 : presc_cnt_q + PRESCALE_W'(1);
        if (prescale_wr_i) begin
            presc_cnt_d = '0;
        end
        pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        // Registered pulse lines up with the cycle in which both counters read zero.
        sync_d    = (pwm_cnt_d == '0) && (presc_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            sync_q      <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            sync_q      <= sync_d;
        end
    end

    assign pwm_cnt_o  = pwm_cnt_q;
    assign pwm_sync_o = sync_q;

`ifdef LED_PWM_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_period_wr_i) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (period_wrap_o) begin
            if (blink_cnt_q == blink_period_i) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    assign blink_phase_o = blink_phase_q;
`endif

endmodule

// File: rtl/nios2_led_pwm.sv
// Avalon-MM LED output controller: DATA/SET/CLEAR, per-channel double-buffered PWM duty.
// Optional hardware blink (BLINK_MASK/BLINK_PERIOD) is built when LED_PWM_BLINK_EN is defined.
module nios2_led_pwm
    import nios2_led_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH   = 18,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] out_port,
    output logic              pwm_sync
);

    logic                  wr_en;
    logic [31:0]           addr_ext;
    logic                  wr_data, wr_set, wr_clear, wr_prescale;
    logic [NUM_CH-1:0]     data_q, data_d;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PWM_BITS-1:0]   shadow_q [NUM_CH];
    logic [PWM_BITS-1:0]   active_q [NUM_CH];
    logic [NUM_CH-1:0]     out_q, out_d;
    logic [NUM_CH-1:0]     blink_off;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  period_wrap;
    logic                  unused_wdata;

    assign wr_en       = chipselect && !write_n;
    assign addr_ext    = 32'(address);
    assign wr_data     = wr_en && (addr_ext == REG_DATA);
    assign wr_set      = wr_en && (addr_ext == REG_SET);
    assign wr_clear    = wr_en && (addr_ext == REG_CLEAR);
    assign wr_prescale = wr_en && (addr_ext == REG_PRESCALE);
    assign unused_wdata = ^writedata;

`ifdef LED_PWM_BLINK_EN
    logic                  wr_blink_mask, wr_blink_period;
    logic [NUM_CH-1:0]     blink_mask_q;
    logic [BLINK_W-1:0]    blink_period_q;
    logic                  blink_phase;

    assign wr_blink_mask   = wr_en && (addr_ext == REG_BLINK_MASK);
    assign wr_blink_period = wr_en && (addr_ext == REG_BLINK_PERIOD);
    assign blink_off       = blink_phase ? blink_mask_q : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask_q   <= '0;
            blink_period_q <= '0;
        end else begin
            if (wr_blink_mask) begin
                blink_mask_q <= writedata[NUM_CH-1:0];
            end
            if (wr_blink_period) begin
                blink_period_q <= writedata[BLINK_W-1:0];
            end
        end
    end
`else
    assign blink_off = '0;
`endif

    nios2_led_pwm_timebase #(
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk               (clk),
        .reset_n           (reset_n),
        .prescale_i        (prescale_q),
        .prescale_wr_i     (wr_prescale),
`ifdef LED_PWM_BLINK_EN
        .blink_period_i    (blink_period_q),
        .blink_period_wr_i (wr_blink_period),
        .blink_phase_o     (blink_phase),
`endif
        .pwm_cnt_o         (pwm_cnt),
        .period_wrap_o     (period_wrap),
        .pwm_sync_o        (pwm_sync)
    );

    always_comb begin
        data_d = data_q;
        if (wr_data) begin
            data_d = writedata[NUM_CH-1:0];
        end else if (wr_set) begin
            data_d = data_q | writedata[NUM_CH-1:0];
        end else if (wr_clear) begin
            data_d = data_q & ~writedata[NUM_CH-1:0];
        end
    end

    // All-ones duty bypasses the compare so a full-scale channel never drops for a clock.
    always_comb begin
        out_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            out_d[i] = data_q[i] && !blink_off[i] &&
                       ((active_q[i] == '1) || (pwm_cnt < active_q[i]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            prescale_q <= '0;
            out_q      <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '1;
                active_q[i] <= '1;
            end
        end else begin
            data_q <= data_d;
            out_q  <= out_d;
            if (wr_prescale) begin
                prescale_q <= writedata[PRESCALE_W-1:0];
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (period_wrap) begin
                    active_q[i] <= shadow_q[i];
                end
                if (wr_en && (addr_ext == REG_DUTY_BASE + i)) begin
                    shadow_q[i] <= writedata[PWM_BITS-1:0];
                end
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (addr_ext)
            REG_DATA:         readdata = 32'(data_q);
            REG_PRESCALE:     readdata = 32'(prescale_q);
`ifdef LED_PWM_BLINK_EN
            REG_BLINK_MASK:   readdata = 32'(blink_mask_q);
            REG_BLINK_PERIOD: readdata = 32'(blink_period_q);
`endif
            default:          readdata = '0;
        endcase
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (addr_ext == REG_DUTY_BASE + i) begin
                readdata = 32'(shadow_q[i]);
            end
        end
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_nios2_led_pwm.sv
// Scoreboard bench for nios2_led_pwm: a period-position reference model predicts every
// output cycle and every read; a separate monitor pops and compares.
`timescale 1ns/1ps
module tb_nios2_led_pwm;
    import nios2_led_pwm_pkg::*;

    localparam int unsigned NCH   = 18;
    localparam int unsigned PB    = 8;
    localparam int unsigned DMAX  = 255;
    localparam int unsigned DMASK = 32'h3FFFF;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [4:0]      address = '0;
    logic            chipselect = 1'b0;
    logic            write_n = 1'b1;
    logic [31:0]     writedata = '0;
    logic [31:0]     readdata;
    logic [NCH-1:0]  out_port;
    logic            pwm_sync;

    always #5 clk = ~clk;

    nios2_led_pwm #(.NUM_CH(NCH), .PWM_BITS(PB), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pwm_sync   (pwm_sync)
    );

    typedef struct { logic [NCH-1:0] o; logic s; } exp_t;
    typedef struct { int unsigned a; logic [31:0] v; } rexp_t;
    exp_t  outq[$];
    rexp_t rdq[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time is a position within the PWM period.
    int unsigned m_data, m_P, m_pos, m_bmask, m_bper, m_wraps;
    int unsigned m_shadow [NCH];
    int unsigned m_active [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_read(input int unsigned a);
        if (a == REG_DATA) return m_data;
        if (a == REG_PRESCALE) return m_P;
`ifdef LED_PWM_BLINK_EN
        if (a == REG_BLINK_MASK) return m_bmask;
        if (a == REG_BLINK_PERIOD) return m_bper;
`endif
        if (a >= REG_DUTY_BASE && a < REG_DUTY_BASE + NCH) return m_shadow[a - REG_DUTY_BASE];
        return 32'h0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int unsigned pwm, presc, a, np;
        logic [31:0] d;
        logic        wr, blink_on;
        logic [NCH-1:0] eo;
        exp_t e;
        if (!reset_n) begin
            m_data = 0; m_P = 0; m_pos = 0; m_bmask = 0; m_bper = 0; m_wraps = 0;
            for (int i = 0; i < NCH; i++) begin
                m_shadow[i] = DMAX;
                m_active[i] = DMAX;
            end
            outq.delete();
        end else begin
            wr = chipselect && !write_n;
            a  = 32'(address);
            d  = writedata;
            pwm   = m_pos / (m_P + 1);
            presc = m_pos % (m_P + 1);
            blink_on = 1'b0;
`ifdef LED_PWM_BLINK_EN
            blink_on = ((m_wraps / (m_bper + 1)) % 2) == 1;
`endif
            eo = '0;
            for (int i = 0; i < NCH; i++) begin
                if (m_data[i] && (m_active[i] == DMAX || pwm < m_active[i]) && !(blink_on && m_bmask[i]))
                    eo[i] = 1'b1;
            end
            m_pos = (m_pos + 1) % ((m_P + 1) * 256);
            if (presc == m_P && pwm == DMAX) begin
                for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
                m_wraps++;
            end
            if (wr) begin
                if (a == REG_DATA) m_data = d & DMASK;
                else if (a == REG_SET) m_data = m_data | (d & DMASK);
                else if (a == REG_CLEAR) m_data = m_data & ~(d & DMASK);
                else if (a == REG_PRESCALE) begin
                    np    = d & 32'hFFFF;
                    pwm   = m_pos / (m_P + 1);
                    m_P   = np;
                    m_pos = pwm * (np + 1);
                end
`ifdef LED_PWM_BLINK_EN
                else if (a == REG_BLINK_MASK) m_bmask = d & DMASK;
                else if (a == REG_BLINK_PERIOD) begin
                    m_bper  = d & 32'hFFFF;
                    m_wraps = 0;
                end
`endif
                else if (a >= REG_DUTY_BASE && a < REG_DUTY_BASE + NCH)
                    m_shadow[a - REG_DUTY_BASE] = d & DMAX;
            end
            e.o = eo;
            e.s = (m_pos == 0);
            outq.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t  e;
        rexp_t r;
        if (!reset_n) begin
            check("reset_out_port", 32'(out_port), 32'h0);
            check("reset_pwm_sync", 32'(pwm_sync), 32'h0);
        end else begin
            if (outq.size() > 0) begin
                e = outq.pop_front();
                check("out_port", 32'(out_port), 32'(e.o));
                check("pwm_sync", 32'(pwm_sync), 32'(e.s));
            end
            if (chipselect && write_n && rdq.size() > 0) begin
                r = rdq.pop_front();
                check($sformatf("readdata@%0d", r.a), readdata, r.v);
            end
        end
    end

    task automatic wr(input int unsigned a, input logic [31:0] d);
        address = 5'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input int unsigned a);
        rexp_t r;
        address = 5'(a); chipselect = 1'b1; write_n = 1'b1;
        r.a = a; r.v = model_read(a);
        rdq.push_back(r);
        @(posedge clk); #1;
        chipselect = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_sync(input int unsigned budget);
        bit seen = 1'b0;
        for (int unsigned k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (pwm_sync) seen = 1'b1;
        end
        n_checks++;
        if (seen) n_pass++;
        else $display("FAIL sync_wait: no pwm_sync within %0d clocks", budget);
        @(posedge clk); #1;
    endtask

    initial begin
        int unsigned op, a;
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd(REG_DATA); rd(REG_PRESCALE); rd(REG_DUTY_BASE); rd(REG_DUTY_BASE + 17); rd(REG_BLINK_PERIOD);

        wr(REG_DATA, 32'h0003FFFF); rd(REG_DATA); idle(3);
        wr(REG_DATA, 32'h000000F0); wr(REG_SET, 32'h3); wr(REG_CLEAR, 32'h10);
        rd(REG_DATA); rd(REG_SET); rd(REG_CLEAR);

        wr(REG_DATA, 32'h1); wr(REG_DUTY_BASE, 32'd64); wait_sync(600); idle(600);
        wr(REG_DUTY_BASE, 32'd0); idle(520);
        wr(REG_DUTY_BASE, 32'hFFFF_FFFF); idle(520);

        wr(REG_DUTY_BASE, 32'd64); wait_sync(600); idle(99);
        wr(REG_DUTY_BASE, 32'd32); rd(REG_DUTY_BASE); idle(600);

        wr(REG_DATA, 32'h0003FFFF); wr(REG_PRESCALE, 32'hABCD_0003); rd(REG_PRESCALE);
        wait_sync(2100); idle(2100);
        idle(37); wr(REG_PRESCALE, 32'd3); idle(1100);
        wr(REG_PRESCALE, 32'd1); idle(600); wr(REG_PRESCALE, 32'd0);

        wr(REG_BLINK_MASK, 32'h1); wr(REG_BLINK_PERIOD, 32'h1); wr(REG_DUTY_BASE, 32'd255);
        wait_sync(600); idle(1300);
        rd(REG_BLINK_PERIOD); rd(REG_BLINK_MASK);

        for (int unsigned it = 0; it < 400; it++) begin
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 10);
            d  = $urandom();
            if (a == REG_PRESCALE || a == REG_BLINK_PERIOD)
                d = {d[31:16], 16'($urandom_range(0, 2))};
            if (op < 4) wr(a, d);
            else if (op < 7) rd(a);
            else idle($urandom_range(1, 40));
        end

        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rd(REG_DATA); rd(REG_PRESCALE); rd(REG_DUTY_BASE); rd(REG_DUTY_BASE + 5); rd(REG_BLINK_MASK);
        wr(REG_DATA, 32'h0003FFFF); idle(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
